uart_port: RTL

Parametrised memory-mapped UART peripheral for the 0xE000xxxx hardware-register space, replacing the fixed-rate UART/FIFO pair. Provides 8N1 transmit and receive, a programmable baud divisor, configurable-depth TX/RX FIFOs, sticky error flags and a level interrupt. It connects to the CPU data bus with the same single-cycle request/ack protocol as the other hardware registers.

---
 rtl/uart_port.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART with programmable divisor, TX/RX FIFOs, sticky errors and a level irq.
// Bus: request in cycle N is answered (ack, rdata) in N+1; side effects land at the end of N.
module uart_port #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpud_request,
  input  logic [7:0]  cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        UART_TX,
  input  logic        UART_RX,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthW = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(4);
  localparam logic [DIV_W-1:0] ResetDiv = DIV_W'(DEFAULT_DIV);

  // Bus decode
  logic rd_en, wr_en, sel_data, sel_stat, sel_div, sel_ien;
  assign rd_en    = cpud_request & ~cpud_write;
  assign wr_en    = cpud_request & cpud_write;
  assign sel_data = (cpud_addr == 8'h00);
  assign sel_stat = (cpud_addr == 8'h04);
  assign sel_div  = (cpud_addr == 8'h08);
  assign sel_ien  = (cpud_addr == 8'h0C);

  logic unused_bus;
  assign unused_bus = ^{cpud_wdata, cpud_byte_enable};

  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [DIV_W-1:0] div_q, div_new;
  logic [2:0]       irq_en_q;
  logic             irq_q;
  logic             rx_ovf_q, frame_q, tx_ovf_q;
  logic             rx_ovf_set, frame_set, tx_ovf_set, stat_clr;

  // TX FIFO
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_q, tx_rd_q, tx_count;
  logic        tx_empty, tx_full, tx_push_req, tx_push, tx_pop;
  assign tx_count    = tx_wr_q - tx_rd_q;
  assign tx_empty    = (tx_count == '0);
  assign tx_full     = (tx_count == DepthW);
  assign tx_push_req = wr_en & sel_data & cpud_byte_enable[0];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;

  // RX FIFO
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr_q, rx_rd_q, rx_count;
  logic        rx_empty, rx_full, rx_push, rx_pop;
  assign rx_count = rx_wr_q - rx_rd_q;
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == DepthW);
  assign rx_pop   = rd_en & sel_data & ~rx_empty;

  // TX shifter
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic             tx_line_q, tx_line_d, tx_load, tx_bit_done, tx_idle;
  assign tx_bit_done = (tx_cnt_q == tx_div_q - DivOne);
  assign tx_idle     = tx_empty & (tx_state_q == TxIdle);
  assign tx_pop      = tx_load;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + DivOne;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_line_d  = tx_line_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        tx_load   = ~tx_empty;
      end
      TxStart: if (tx_bit_done) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_state_d = TxData;
      end
      TxData: if (tx_bit_done) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_line_d  = 1'b1;
          tx_state_d = TxStop;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_line_d  = tx_shift_q[1];
        end
      end
      TxStop: if (tx_bit_done) begin
        tx_cnt_d   = '0;
        tx_state_d = TxIdle;
        tx_load    = ~tx_empty;
      end
      default: tx_state_d = TxIdle;
    endcase
    // Back-to-back frames: a queued byte loads straight out of STOP.
    if (tx_load) begin
      tx_state_d = TxStart;
      tx_div_d   = div_q;
      tx_shift_d = tx_mem[tx_rd_q[AW-1:0]];
      tx_line_d  = 1'b0;
      tx_cnt_d   = '0;
    end
  end

  // RX sampler
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  rx_state_e        rx_state_q, rx_state_d;
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q, rx_s, rx_half, rx_bit_done;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  assign rx_s        = rx_sync_q[1];
  assign rx_half     = (rx_cnt_q == (rx_div_q >> 1) - DivOne);
  assign rx_bit_done = (rx_cnt_q == rx_div_q - DivOne);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DivOne;
    rx_div_d   = rx_div_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_push    = 1'b0;
    rx_ovf_set = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s) begin
          rx_div_d   = div_q;
          rx_state_d = RxStart;
        end
      end
      RxStart: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? RxIdle : RxData;
      end
      RxData: if (rx_bit_done) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RxStop: if (rx_bit_done) begin
        rx_cnt_d   = '0;
        rx_state_d = RxIdle;
        if (!rx_s)                  frame_set  = 1'b1;
        else if (rx_full && !rx_pop) rx_ovf_set = 1'b1;
        else                        rx_push    = 1'b1;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Divisor write with byte lanes; stored value never drops below 4
  always_comb begin
    for (int unsigned i = 0; i < DIV_W; i++) begin
      div_new[i] = cpud_byte_enable[i/8] ? cpud_wdata[i] : div_q[i];
    end
    if (div_new < MinDiv) div_new = MinDiv;
  end

  assign stat_clr = wr_en & sel_stat & cpud_byte_enable[0];

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      if (sel_data) begin
        rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'b0, rx_mem[rx_rd_q[AW-1:0]]};
      end else if (sel_stat) begin
        rdata_d = {16'(DepthW - tx_count), 10'b0, tx_ovf_q, frame_q, rx_ovf_q,
                   tx_idle, tx_full, ~rx_empty};
      end else if (sel_div) begin
        rdata_d = 32'(div_q);
      end else if (sel_ien) begin
        rdata_d = {29'b0, irq_en_q};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= cpud_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      div_q      <= ResetDiv;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      rx_ovf_q   <= 1'b0;
      frame_q    <= 1'b0;
      tx_ovf_q   <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= ResetDiv;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= ResetDiv;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      ack_q   <= cpud_request;
      rdata_q <= rdata_d;
      if (wr_en && sel_div) div_q <= div_new;
      if (wr_en && sel_ien && cpud_byte_enable[0]) irq_en_q <= cpud_wdata[2:0];
      // Set beats a same-cycle write-one-to-clear.
      rx_ovf_q <= (rx_ovf_q & ~(stat_clr & cpud_wdata[3])) | rx_ovf_set;
      frame_q  <= (frame_q  & ~(stat_clr & cpud_wdata[4])) | frame_set;
      tx_ovf_q <= (tx_ovf_q & ~(stat_clr & cpud_wdata[5])) | tx_ovf_set;
      irq_q    <= |(irq_en_q & {rx_ovf_q | frame_q | tx_ovf_q, tx_empty, ~rx_empty});
      if (tx_push) tx_wr_q <= tx_wr_q + PtrOne;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrOne;
      if (rx_push) rx_wr_q <= rx_wr_q + PtrOne;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrOne;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
      rx_sync_q  <= {rx_sync_q[0], UART_RX};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  assign cpud_ack   = ack_q;
  assign cpud_rdata = rdata_q;
  assign UART_TX    = tx_line_q;
  assign irq        = irq_q;

endmodule
